bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter and bus multiplexer for the shared 8-bit-address system bus. It grants the bus to master M0 or M1 and routes the granted master's address, write strobe and write data onto the shared slave-side bus. It also returns registered read data from the four slave windows (S0 0x00–0x1F, S1 0x20–0x3F, S2 0x40–0x5F, S3 0x60–0x7F). It sits between the masters and the address decoder and slaves, and enforces fairness with round-robin ordering and a hold-limit counter.

## Interface
- ADDR_W, 8, address width (window boundaries fixed as above; addresses ≥ 0x80 hit no slave)
- DATA_W, 32, data width
- MAX_HOLD, 16, maximum consecutive granted cycles while the other master is waiting (≥ 2)

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- m0_req, m1_req  in  1  bus request; held high for the whole transfer sequence
- m0_wr, m1_wr  in  1  1 = write, 0 = read, for the current cycle
- m0_addr, m1_addr  in  ADDR_W  master address
- m0_dout, m1_dout  in  DATA_W  master write data
- m0_grant, m1_grant  out  1  registered grant; at most one high
- s_addr  out  ADDR_W  shared bus address (to decoder and slaves)
- s_wr  out  1  shared write strobe
- s_din  out  DATA_W  shared write data
- s0_dout..s3_dout  in  DATA_W  slave read data, valid the cycle after the address
- m_din  out  DATA_W  read data returned to the masters
- rd_valid  out  1  m_din valid for the master granted in the previous cycle

## Operation
- FSM states:
  - IDLE: reset state; no grant.
  - GNT0: M0 owns the bus.
  - GNT1: M1 owns the bus.
- `last` register: records the last-served master. Reset value = M1, so M0 wins the first tie.
- From IDLE:
  - Both requesting → grant the master ≠ `last`.
  - Only one requesting → grant that master.
  - Neither requesting → stay in IDLE.
- From GNTx:
  - mx_req low, other master requesting → go directly to GNT(other), with no IDLE bubble.
  - mx_req low, other master idle → go to IDLE.
  - mx_req high, `hold_cnt` = MAX_HOLD−1, other master requesting → force switch to GNT(other).
  - Otherwise → stay in GNTx.
- `last` updates on every entry to GNT0/GNT1.
- `hold_cnt` counts granted cycles in the current tenure:
  - It clears on any grant change and in IDLE.
  - It saturates at MAX_HOLD−1 when the other master is not requesting, so the owner keeps the bus indefinitely if uncontested.
- Grants decode from state: m0_grant = (state == GNT0), m1_grant = (state == GNT1).
- Bus mux (combinational from state):
  - In GNTx: s_addr/s_wr/s_din = mx_addr/mx_wr/mx_dout.
  - In IDLE: all outputs 0. s_wr is never high without a grant.
- Read return:
  - On each granted cycle with s_wr = 0, register `rsel` (decode of s_addr into S0..S3 or none).
  - On each granted cycle with s_wr = 0, also set rd_valid_q = 1. On every other cycle rd_valid_q = 0.
  - m_din = s{rsel}_dout when rd_valid = 1 and rsel is a valid slave; otherwise m_din = 0.
  - An address ≥ 0x80 still produces rd_valid = 1, with m_din = 0.
- Reset values:
  - state = IDLE, `last` = M1, hold_cnt = 0, rd_valid = 0, rsel = none.
  - Therefore all grants, s_addr, s_wr, s_din and m_din are 0.

## Timing
- Request → grant latency: req sampled at edge n, grant high after edge n (1 cycle).
- Release → regrant: the owner drops req in cycle k. The grant drops after edge k, and the waiting master's grant rises after the same edge.
- The master must keep req high during its last transfer cycle.
- Forced switch: the owner may hold at most MAX_HOLD consecutive cycles while contested. The loser sees its grant drop with no warning and must re-request, holding req high.
- Read latency: address on the bus in cycle t → m_din and rd_valid in cycle t+1. This holds across a grant change, so the previous owner's last read data appears in the new owner's first cycle.
- Writes complete in the granted cycle; no write acknowledge.
- Reset asserted mid-transfer:
  - Next edge goes to IDLE, grants drop and rd_valid clears.
  - A pending read is discarded.
  - Requests are sampled only after reset deasserts.

## Test plan
- **Reset:** hold reset 2 cycles with both req high → grants 0, s_wr 0, m_din 0, rd_valid 0. Release reset → m0_grant rises 1 cycle later (`last` = M1).
- **Single master read:** M1 alone, req, read addr 0x45, s2_dout = 0xA5A5_0002 → m1_grant after 1 cycle; next cycle m_din = 0xA5A5_0002, rd_valid = 1.
- **Handover:** both request; M0 granted. M0 drops req → m1_grant rises on the same edge m0_grant falls, with no IDLE cycle. Then both re-request → M0 granted next (round-robin).
- **Starvation limit:** MAX_HOLD = 4. M0 holds req continuously; M1 requests from cycle 0 of M0's tenure → M0 granted exactly 4 cycles, then M1 granted.
- **Unmapped and write:**
  - M0 writes 0x1234 to 0x7F → s_addr = 0x7F, s_wr = 1, s_din = 0x1234 for 1 cycle.
  - M0 reads 0x90 → rd_valid = 1, m_din = 0.
- **Reset mid-read:** reset asserted in the cycle after a read address → rd_valid = 0 and grants 0 on the next edge.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with hold limit, bus mux and registered read return
module bus_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_wr,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_wr,
  output logic [DATA_W-1:0] s_din,
  input  logic [DATA_W-1:0] s0_dout,
  input  logic [DATA_W-1:0] s1_dout,
  input  logic [DATA_W-1:0] s2_dout,
  input  logic [DATA_W-1:0] s3_dout,
  output logic [DATA_W-1:0] m_din,
  output logic              rd_valid
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  localparam int HW = $clog2(MAX_HOLD);
  state_t state, next;
  logic last;
  logic [HW-1:0] hold_cnt;
  logic hold_max;
  logic granted;
  logic rd_valid_q;
  logic rsel_v;
  logic [1:0] rsel;
  assign hold_max = hold_cnt == HW'(MAX_HOLD - 1);
  assign granted  = state != IDLE;
  assign m0_grant = state == GNT0;
  assign m1_grant = state == GNT1;
  assign rd_valid = rd_valid_q;
  assign m_din    = !(rd_valid_q && rsel_v) ? '0 :
                    rsel == 2'd0 ? s0_dout :
                    rsel == 2'd1 ? s1_dout :
                    rsel == 2'd2 ? s2_dout : s3_dout;
  // next-state arbitration (last=1 means M1 was served last) and bus mux from state
  always_comb begin
    next   = state;
    s_addr = '0;
    s_wr   = 1'b0;
    s_din  = '0;
    case (state)
      IDLE: next = (m0_req && m1_req) ? (last ? GNT0 : GNT1) :
                   m0_req ? GNT0 : m1_req ? GNT1 : IDLE;
      GNT0: next = (m1_req && (!m0_req || hold_max)) ? GNT1 : m0_req ? GNT0 : IDLE;
      GNT1: next = (m0_req && (!m1_req || hold_max)) ? GNT0 : m1_req ? GNT1 : IDLE;
      default: next = IDLE;
    endcase
    if (state == GNT0) begin
      s_addr = m0_addr;
      s_wr   = m0_wr;
      s_din  = m0_dout;
    end else if (state == GNT1) begin
      s_addr = m1_addr;
      s_wr   = m1_wr;
      s_din  = m1_dout;
    end
  end
  // state, fairness bookkeeping and read-return registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      hold_cnt   <= '0;
      rd_valid_q <= 1'b0;
      rsel_v     <= 1'b0;
      rsel       <= 2'd0;
    end else begin
      state      <= next;
      if (next != IDLE) last <= next == GNT1;
      hold_cnt   <= (next != state || next == IDLE) ? '0 :
                    hold_max ? hold_cnt : hold_cnt + HW'(1);
      rd_valid_q <= granted && !s_wr;
      if (granted && !s_wr) begin
        rsel_v <= s_addr < ADDR_W'(128);
        rsel   <= s_addr[6:5];
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven check of bus_arbiter with a read-data scoreboard
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic m0_req, m1_req, m0_wr, m1_wr;
  logic [7:0] m0_addr, m1_addr, s_addr;
  logic [31:0] m0_dout, m1_dout, s_din, m_din;
  logic m0_grant, m1_grant, s_wr, rd_valid;
  logic [31:0] s0_dout = 32'hA5A5_0000;
  logic [31:0] s1_dout = 32'hA5A5_0001;
  logic [31:0] s2_dout = 32'hA5A5_0002;
  logic [31:0] s3_dout = 32'hA5A5_0003;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic rst, r0, w0;
    logic [7:0] a0;
    logic [31:0] d0;
    logic r1, w1;
    logic [7:0] a1;
    logic [31:0] d1;
    logic g0, g1;
    logic [7:0] sa;
    logic sw;
    logic [31:0] sd;
    logic rv;
  } vec_t;
  vec_t v[$];

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .s_addr(s_addr), .s_wr(s_wr), .s_din(s_din),
    .s0_dout(s0_dout), .s1_dout(s1_dout), .s2_dout(s2_dout), .s3_dout(s3_dout),
    .m_din(m_din), .rd_valid(rd_valid)
  );

  function automatic vec_t mk(input logic rst, r0, w0, input logic [7:0] a0, input logic [31:0] d0,
                              input logic r1, w1, input logic [7:0] a1, input logic [31:0] d1,
                              input logic g0, g1, input logic [7:0] sa, input logic sw,
                              input logic [31:0] sd, input logic rv);
    vec_t x;
    x.rst = rst; x.r0 = r0; x.w0 = w0; x.a0 = a0; x.d0 = d0;
    x.r1 = r1; x.w1 = w1; x.a1 = a1; x.d1 = d1;
    x.g0 = g0; x.g1 = g1; x.sa = sa; x.sw = sw; x.sd = sd; x.rv = rv;
    return x;
  endfunction

  function automatic logic [31:0] slave_data(input logic [7:0] a);
    logic [1:0] idx;
    idx = a[6:5];
    return a < 8'h80 ? (32'hA5A5_0000 | 32'(idx)) : 32'h0;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, step, act, exp);
    end
  endtask

  task automatic run(input vec_t x, input int step);
    logic [31:0] e;
    reset = x.rst;
    m0_req = x.r0; m0_wr = x.w0; m0_addr = x.a0; m0_dout = x.d0;
    m1_req = x.r1; m1_wr = x.w1; m1_addr = x.a1; m1_dout = x.d1;
    @(negedge clk);
    chk("m0_grant", step, 32'(m0_grant), 32'(x.g0));
    chk("m1_grant", step, 32'(m1_grant), 32'(x.g1));
    chk("s_addr", step, 32'(s_addr), 32'(x.sa));
    chk("s_wr", step, 32'(s_wr), 32'(x.sw));
    chk("s_din", step, s_din, x.sd);
    chk("rd_valid", step, 32'(rd_valid), 32'(x.rv));
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty step=%0d got=rd_valid expected=no_read_pending", step);
      end else begin
        e = exp_q.pop_front();
        chk("m_din", step, m_din, e);
      end
    end else chk("m_din_idle", step, m_din, 32'h0);
    if (!x.rst && (x.g0 || x.g1) && !x.sw) exp_q.push_back(slave_data(x.sa));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_wr = 1'b0; m1_wr = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_dout = '0; m1_dout = '0;
    //       rst r0 w0 a0    d0          r1 w1 a1    d1           g0 g1 sa    sw sd           rv
    v.push_back(mk(1, 1, 0, 8'h10, 32'h1111, 1, 0, 8'h45, 32'h2222, 0, 0, 8'h00, 0, 32'h0, 0));
    v.push_back(mk(1, 1, 0, 8'h10, 32'h1111, 1, 0, 8'h45, 32'h2222, 0, 0, 8'h00, 0, 32'h0, 0));
    v.push_back(mk(0, 1, 0, 8'h10, 32'h1111, 1, 0, 8'h45, 32'h2222, 0, 0, 8'h00, 0, 32'h0, 0));
    v.push_back(mk(0, 1, 0, 8'h10, 32'h1111, 1, 0, 8'h45, 32'h2222, 1, 0, 8'h10, 0, 32'h1111, 0));
    v.push_back(mk(0, 0, 0, 8'h10, 32'h1111, 1, 0, 8'h45, 32'h2222, 1, 0, 8'h10, 0, 32'h1111, 1));
    v.push_back(mk(0, 0, 0, 8'h10, 32'h1111, 1, 0, 8'h45, 32'h2222, 0, 1, 8'h45, 0, 32'h2222, 1));
    v.push_back(mk(0, 0, 0, 8'h10, 32'h1111, 0, 0, 8'h45, 32'h2222, 0, 1, 8'h45, 0, 32'h2222, 1));
    v.push_back(mk(0, 0, 0, 8'h10, 32'h1111, 0, 0, 8'h45, 32'h2222, 0, 0, 8'h00, 0, 32'h0, 1));
    v.push_back(mk(0, 0, 0, 8'h10, 32'h1111, 1, 0, 8'h45, 32'h2222, 0, 0, 8'h00, 0, 32'h0, 0));
    v.push_back(mk(0, 0, 0, 8'h10, 32'h1111, 1, 0, 8'h45, 32'h2222, 0, 1, 8'h45, 0, 32'h2222, 0));
    v.push_back(mk(0, 0, 0, 8'h10, 32'h1111, 0, 0, 8'h45, 32'h2222, 0, 1, 8'h45, 0, 32'h2222, 1));
    v.push_back(mk(0, 0, 0, 8'h10, 32'h1111, 0, 0, 8'h45, 32'h2222, 0, 0, 8'h00, 0, 32'h0, 1));
    v.push_back(mk(0, 1, 0, 8'h25, 32'h1111, 1, 0, 8'h65, 32'h2222, 0, 0, 8'h00, 0, 32'h0, 0));
    v.push_back(mk(0, 1, 0, 8'h25, 32'h1111, 1, 0, 8'h65, 32'h2222, 1, 0, 8'h25, 0, 32'h1111, 0));
    v.push_back(mk(0, 1, 0, 8'h25, 32'h1111, 1, 0, 8'h65, 32'h2222, 1, 0, 8'h25, 0, 32'h1111, 1));
    v.push_back(mk(0, 1, 0, 8'h25, 32'h1111, 1, 0, 8'h65, 32'h2222, 1, 0, 8'h25, 0, 32'h1111, 1));
    v.push_back(mk(0, 1, 0, 8'h25, 32'h1111, 1, 0, 8'h65, 32'h2222, 1, 0, 8'h25, 0, 32'h1111, 1));
    v.push_back(mk(0, 1, 0, 8'h25, 32'h1111, 1, 0, 8'h65, 32'h2222, 0, 1, 8'h65, 0, 32'h2222, 1));
    v.push_back(mk(0, 1, 0, 8'h25, 32'h1111, 0, 0, 8'h65, 32'h2222, 0, 1, 8'h65, 0, 32'h2222, 1));
    v.push_back(mk(0, 1, 1, 8'h7F, 32'h1234, 0, 0, 8'h65, 32'h2222, 1, 0, 8'h7F, 1, 32'h1234, 1));
    v.push_back(mk(0, 1, 0, 8'h90, 32'h1234, 0, 0, 8'h65, 32'h2222, 1, 0, 8'h90, 0, 32'h1234, 0));
    v.push_back(mk(0, 1, 0, 8'h10, 32'h1111, 0, 0, 8'h65, 32'h2222, 1, 0, 8'h10, 0, 32'h1111, 1));
    v.push_back(mk(1, 1, 0, 8'h10, 32'h1111, 0, 0, 8'h65, 32'h2222, 1, 0, 8'h10, 0, 32'h1111, 1));
    v.push_back(mk(0, 0, 0, 8'h10, 32'h1111, 0, 0, 8'h65, 32'h2222, 0, 0, 8'h00, 0, 32'h0, 0));
    v.push_back(mk(0, 0, 0, 8'h10, 32'h1111, 0, 0, 8'h65, 32'h2222, 0, 0, 8'h00, 0, 32'h0, 0));
    @(posedge clk);
    #1;
    for (int i = 0; i < v.size(); i++) run(v[i], i);
    run(mk(0, 1, 1, 8'h08, 32'hBEEF, 0, 0, 8'h30, 32'hCAFE, 0, 0, 8'h00, 0, 32'h0, 0), 100);
    for (int k = 0; k < 8; k++)
      run(mk(0, 1, 1, 8'h08, 32'hBEEF, 0, 0, 8'h30, 32'hCAFE, 1, 0, 8'h08, 1, 32'hBEEF, 0), 101 + k);
    run(mk(0, 1, 1, 8'h08, 32'hBEEF, 1, 1, 8'h30, 32'hCAFE, 1, 0, 8'h08, 1, 32'hBEEF, 0), 110);
    run(mk(0, 1, 1, 8'h08, 32'hBEEF, 1, 1, 8'h30, 32'hCAFE, 0, 1, 8'h30, 1, 32'hCAFE, 0), 111);
    run(mk(0, 0, 1, 8'h08, 32'hBEEF, 0, 1, 8'h30, 32'hCAFE, 0, 1, 8'h30, 1, 32'hCAFE, 0), 112);
    run(mk(0, 0, 1, 8'h08, 32'hBEEF, 0, 1, 8'h30, 32'hCAFE, 0, 0, 8'h00, 0, 32'h0, 0), 113);
    chk("sb_leftover", 114, 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
